traffic_light_multi_fsm: RTL and testbench

Parametrised successor to the two-road traffic light FSM. Controls NUM_DIR approaches from per-direction traffic sensors, and grants green to one direction at a time in round-robin order. Adds min/max green timers, a timed yellow phase, an optional all-red clearance phase and an emergency pre-emption input. Sits at the top of the intersection controller and drives the per-direction lamp decoders.

---
 rtl/traffic_pkg.sv | 18 +
 rtl/rr_pick.sv | 30 +++
 rtl/traffic_light_multi_fsm.sv | 120 ++++++++++++
 tb/tb_traffic_light_multi_fsm.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp/phase types and width helpers for the intersection controller
package traffic_pkg;

  typedef enum logic [1:0] {GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10} light_t;

  typedef enum logic [1:0] {PH_GREEN = 2'd0, PH_YELLOW = 2'd1, PH_ALL_RED = 2'd2} phase_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester after cur_idx, wrapping
module rr_pick
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = 4,
  localparam int DIR_W = idx_width(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] req,
  input  logic [DIR_W-1:0]   cur_idx,
  output logic [DIR_W-1:0]   next_idx,
  output logic               valid
);

  logic [DIR_W-1:0] j;

  // Scan from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    next_idx = cur_idx;
    valid    = 1'b0;
    j        = '0;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      j = DIR_W'((32'(cur_idx) + k) % NUM_DIR);
      if (req[j]) begin
        next_idx = j;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_multi_fsm.sv
// rtl/traffic_light_multi_fsm.sv - round-robin multi-approach traffic light with min/max green,
// timed yellow, optional all-red clearance and emergency pre-emption
module traffic_light_multi_fsm
  import traffic_pkg::*;
#(
  parameter int NUM_DIR        = 4,
  parameter int MIN_GREEN      = 4,
  parameter int MAX_GREEN      = 12,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 1,
  localparam int DIR_W = idx_width(NUM_DIR)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_DIR-1:0]     t,
  input  logic                   emerg_req,
  input  logic [DIR_W-1:0]       emerg_dir,
  output logic [2*NUM_DIR-1:0]   lights,
  output logic [DIR_W-1:0]       active_dir,
  output logic [1:0]             phase
);

  // Timer must also cover yellow/all-red counts, so size it for the largest.
  localparam int CNT_MAX = max3(MAX_GREEN, YELLOW_CYCLES, ALL_RED_CYCLES);
  localparam int CNT_W   = idx_width(CNT_MAX + 1);
  localparam int AR_LAST = (ALL_RED_CYCLES > 0) ? ALL_RED_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] T_SAT    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] T_MIN    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL    = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_AR     = CNT_W'(AR_LAST);
  localparam logic [DIR_W:0]   DIR_LIM  = (DIR_W + 1)'(NUM_DIR);
  localparam logic [2*NUM_DIR-1:0] LIGHTS_RST = {{(NUM_DIR - 1){RED}}, GREEN};

  phase_t               phase_q, ph_n;
  logic [DIR_W-1:0]     active_q, dir_n, next_dir_q, nd_n, pick;
  logic [CNT_W-1:0]     timer_q, tmr_n;
  logic [2*NUM_DIR-1:0] lights_q, lights_n;
  logic                 other_req, ev, go;

  rr_pick #(.NUM_DIR(NUM_DIR)) u_pick (
    .req      (t),
    .cur_idx  (active_q),
    .next_idx (pick),
    .valid    (other_req)
  );

  always_comb begin
    // An out-of-range emergency direction is treated as no emergency at all.
    ev    = emerg_req && ({1'b0, emerg_dir} < DIR_LIM);
    ph_n  = phase_q;
    dir_n = active_q;
    nd_n  = next_dir_q;
    go    = 1'b0;
    tmr_n = (timer_q == T_SAT) ? timer_q : timer_q + CNT_W'(1);
    case (phase_q)
      PH_GREEN: begin
        go = (ev && (emerg_dir != active_q)) ||
             (!ev && other_req && (((timer_q >= T_MIN) && !t[active_q]) || (timer_q >= T_MAX)));
        if (go) begin
          ph_n  = PH_YELLOW;
          nd_n  = ev ? emerg_dir : pick;
          tmr_n = '0;
        end
      end
      PH_YELLOW: begin
        if (timer_q == T_YEL) begin
          tmr_n = '0;
          if (ALL_RED_CYCLES == 0) begin
            ph_n  = PH_GREEN;
            dir_n = ev ? emerg_dir : next_dir_q;
          end else begin
            ph_n = PH_ALL_RED;
          end
        end
      end
      PH_ALL_RED: begin
        if (timer_q == T_AR) begin
          ph_n  = PH_GREEN;
          tmr_n = '0;
          dir_n = ev ? emerg_dir : next_dir_q;
        end
      end
      default: begin
        ph_n  = PH_GREEN;
        tmr_n = '0;
      end
    endcase

    lights_n = {NUM_DIR{RED}};
    for (int i = 0; i < NUM_DIR; i++) begin
      if (DIR_W'(i) == dir_n) begin
        if (ph_n == PH_GREEN)       lights_n[2*i +: 2] = GREEN;
        else if (ph_n == PH_YELLOW) lights_n[2*i +: 2] = YELLOW;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= PH_GREEN;
      active_q   <= '0;
      next_dir_q <= '0;
      timer_q    <= '0;
      lights_q   <= LIGHTS_RST;
    end else begin
      phase_q    <= ph_n;
      active_q   <= dir_n;
      next_dir_q <= nd_n;
      timer_q    <= tmr_n;
      lights_q   <= lights_n;
    end
  end

  assign lights     = lights_q;
  assign active_dir = active_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_multi_fsm.sv
// tb/tb_traffic_light_multi_fsm.sv - directed self-checking bench for traffic_light_multi_fsm
module tb_traffic_light_multi_fsm;

  logic       clk;
  logic       reset;
  logic [3:0] t;
  logic       emerg_req;
  logic [1:0] emerg_dir;
  logic [7:0] lights;
  logic [1:0] active_dir;
  logic [1:0] phase;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] PG = 2'd0, PY = 2'd1, PR = 2'd2;

  traffic_light_multi_fsm #(
    .NUM_DIR(4), .MIN_GREEN(4), .MAX_GREEN(12), .YELLOW_CYCLES(3), .ALL_RED_CYCLES(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .t          (t),
    .emerg_req  (emerg_req),
    .emerg_dir  (emerg_dir),
    .lights     (lights),
    .active_dir (active_dir),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lamp(input logic [1:0] ph, input logic [1:0] d);
    logic [7:0] l;
    l = 8'b10101010;
    if (ph == PG)      l[2*d +: 2] = 2'b00;
    else if (ph == PY) l[2*d +: 2] = 2'b01;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] ph, input logic [1:0] d);
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".dir"}, 32'(active_dir), 32'(d));
    chk({tag, ".lights"}, 32'(lights), 32'(lamp(ph, d)));
  endtask

  // Reset released at a falling edge; the green phase then sits at timer 0.
  task automatic do_reset(input logic [3:0] tv);
    @(negedge clk);
    reset     = 1'b0;
    t         = tv;
    emerg_req = 1'b0;
    emerg_dir = 2'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic handoff(input string tag, input logic [1:0] from, input logic [1:0] to,
                         input int green_steps);
    for (int s = 0; s < green_steps; s++) begin
      @(negedge clk);
      chk_state({tag, ".green"}, PG, from);
    end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk_state({tag, ".yellow"}, PY, from);
    end
    @(negedge clk);
    chk_state({tag, ".allred"}, PR, from);
    @(negedge clk);
    chk_state({tag, ".newgreen"}, PG, to);
  endtask

  initial begin
    reset     = 1'b1;
    t         = 4'b0000;
    emerg_req = 1'b0;
    emerg_dir = 2'd0;

    // 1: asynchronous reset values, then idle with no requests
    #1 reset = 1'b0;
    #1;
    chk("t1.rst_lights", 32'(lights), 32'(8'b10101000));
    chk("t1.rst_dir", 32'(active_dir), 32'(2'd0));
    chk("t1.rst_phase", 32'(phase), 32'(PG));
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk_state("t1.idle", PG, 2'd0);
    end

    // 2: min-green hand-off dir0 -> dir2
    do_reset(4'b0100);
    chk_state("t2.start", PG, 2'd0);
    handoff("t2", 2'd0, 2'd2, 3);
    chk("t2.g2_lit", 32'(lights), 32'(8'b10001010));

    // 3: max-green forced hand-off dir0 -> dir1 with own request held
    do_reset(4'b0011);
    handoff("t3", 2'd0, 2'd1, 11);
    chk("t3.g1_lit", 32'(lights), 32'(8'b10100010));

    // 4: wrap-around from dir3 lands on dir0, not dir2
    do_reset(4'b1000);
    handoff("t4a", 2'd0, 2'd3, 3);
    t = 4'b0101;
    handoff("t4b", 2'd3, 2'd0, 3);

    // 5: emergency pre-emption at timer 1, hold while asserted, then resume
    do_reset(4'b0000);
    @(negedge clk);
    chk_state("t5.pre", PG, 2'd0);
    emerg_req = 1'b1;
    emerg_dir = 2'd2;
    handoff("t5a", 2'd0, 2'd2, 0);
    t = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk_state("t5.hold", PG, 2'd2);
    end
    emerg_req = 1'b0;
    handoff("t5b", 2'd2, 2'd3, 0);

    // 7: emergency raised during yellow redirects the upcoming green
    do_reset(4'b0100);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk_state("t7.green", PG, 2'd0);
    end
    @(negedge clk);
    chk_state("t7.y0", PY, 2'd0);
    emerg_req = 1'b1;
    emerg_dir = 2'd1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk_state("t7.yellow", PY, 2'd0);
    end
    @(negedge clk);
    chk_state("t7.allred", PR, 2'd0);
    @(negedge clk);
    chk_state("t7.redirect", PG, 2'd1);
    emerg_req = 1'b0;

    // 6: reset asserted mid-yellow between clock edges
    do_reset(4'b0100);
    repeat (4) @(negedge clk);
    chk_state("t6.in_yellow", PY, 2'd0);
    #2 reset = 1'b0;
    #1;
    chk_state("t6.async", PG, 2'd0);
    chk("t6.lit", 32'(lights), 32'(8'b10101000));
    @(negedge clk);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
